final_write_address_generator: RTL and testbench
================================================

FINAL_WRITE_ADDRESS_GENERATOR -- requirements
Module: final_write_address_generator

Interface
REQ-001 The block SHALL have parameter stage_FFT, default 2, meaning the current FFT stage (legal 2..SIZE), with butterfly half-span H = 2^(stage_FFT-1).
REQ-002 The block SHALL have parameter N, default 16, meaning the number of points, equal to 2^SIZE.
REQ-003 The block SHALL have parameter SIZE, default 4, meaning the address width.
REQ-004 The block SHALL have parameter DATA_W, default 16, meaning the width of each real and imaginary sample.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start_stage, input, 1 bit: a one-cycle pulse that arms the write-back of one stage.
REQ-008 The block SHALL have port din_valid, input, 1 bit: a butterfly result is present on din_re and din_im.
REQ-009 The block SHALL have ports din_re and din_im, input, DATA_W bits each: the butterfly result, upper output first, then lower output.
REQ-010 The block SHALL have port en_wr, output, 1 bit: the RAM write enable.
REQ-011 The block SHALL have port wr_ptr, output, SIZE bits: the RAM write address.
REQ-012 The block SHALL have ports wr_re and wr_im, output, DATA_W bits each: the registered write data.
REQ-013 The block SHALL have port stage_done, output, 1 bit: a one-cycle pulse after the last write of the stage.
REQ-014 The block SHALL have port busy, output, 1 bit: high from acceptance of start_stage until stage_done.
REQ-015 The block SHALL have port err_unexp, output, 1 bit: sticky flag set when din_valid arrives while not busy.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WR_A, WR_B and DONE.
REQ-017 IDLE SHALL go to WR_A on start_stage; otherwise it SHALL stay in IDLE.
REQ-018 WR_A SHALL go to WR_B on din_valid; otherwise it SHALL hold.
REQ-019 WR_B SHALL go to DONE on din_valid when the pair counter p = N/2-1, SHALL go to WR_A on din_valid otherwise, and SHALL hold without din_valid.
REQ-020 DONE SHALL go to IDLE unconditionally.
REQ-021 For pair index p (0..N/2-1), the block SHALL compute k = p mod H and g = p div H.
REQ-022 The upper address SHALL be A = g*2H + k, and the lower address SHALL be B = A + H.
REQ-023 Address arithmetic SHALL use shifts and adds only, truncated to SIZE bits.
REQ-024 The block SHALL be able to cover all N addresses exactly once per stage.
REQ-025 A din_valid sample accepted in WR_A SHALL be written to A, and one accepted in WR_B SHALL be written to B.
REQ-026 The pair counter p SHALL increment after the write to B.
REQ-027 Write latency SHALL be exactly 1 cycle: en_wr, wr_ptr, wr_re and wr_im SHALL be registered and valid in the cycle after din_valid is sampled.
REQ-028 en_wr SHALL be high for exactly one cycle per accepted sample, so there are exactly N en_wr pulses per stage.
REQ-029 Gaps in din_valid SHALL be allowed, and the address SHALL NOT advance during a gap.
REQ-030 stage_done SHALL pulse high for one cycle, one cycle after the final en_wr.
REQ-031 busy SHALL drop in the same cycle that stage_done is high.
REQ-032 start_stage received while busy SHALL be ignored and SHALL NOT restart counters.
REQ-033 din_valid received in IDLE or DONE SHALL produce no write, SHALL set err_unexp, and err_unexp SHALL stay set until rst.
REQ-034 When start_stage and din_valid occur in the same cycle in IDLE, the block SHALL arm and ignore the din_valid sample, and SHALL also set err_unexp.
REQ-035 On returning to IDLE, p SHALL wrap to 0, so a new stage starts at address 0.
REQ-036 wr_ptr and wr_re/wr_im SHALL hold their last values when en_wr is low.

Reset
REQ-037 While rst is high at a clock edge, the FSM SHALL enter IDLE.
REQ-038 Reset SHALL clear p to 0.
REQ-039 Reset SHALL force en_wr, stage_done, busy and err_unexp to 0.
REQ-040 Reset SHALL force wr_ptr, wr_re and wr_im to 0.
REQ-041 rst asserted mid-stage SHALL abort the stage with no further en_wr and no stage_done.
REQ-042 After reset, the next start_stage SHALL begin the sequence at address 0.

Verification
REQ-043 Scenario: N=16, stage_FFT=2, start_stage, then 16 consecutive din_valid -> wr_ptr = 0,2,1,3,4,6,5,7,8,10,9,11,12,14,13,15, each one cycle after its sample; stage_done one cycle after the last write.
REQ-044 Scenario: stage_FFT=3 -> wr_ptr = 0,4,1,5,2,6,3,7,8,12,9,13,10,14,11,15; stage_FFT=4 -> wr_ptr = 0,8,1,9,...,7,15.
REQ-045 Scenario: stage_FFT=2, din_valid toggling 1,0,1,0 with din_re = sample index -> 16 en_wr pulses, each wr_re matching its address, and no address skips during the gaps.
REQ-046 Scenario: din_valid in IDLE -> no en_wr and err_unexp = 1 until rst; start_stage on the 5th sample of a stage -> ignored, and the sequence completes normally.
REQ-047 Scenario: rst after 7 writes -> en_wr = 0, busy = 0, no stage_done; a new start_stage then writes address 0 first.
REQ-048 Scenario: two back-to-back stages with start_stage one cycle after stage_done -> both produce the full 16-address sequence.

Source files
------------

// File: rtl/final_write_address_generator.sv
`default_nettype none
// ============================================================================
// Module      : final_write_address_generator
// Description : Write-back address sequencer for one radix-2 FFT stage. It
//               steers butterfly result pairs to the A / A+H RAM locations.
// Revision    : 1.0 - initial release
// ============================================================================
module final_write_address_generator #(
    parameter int stage_FFT = 2,
    parameter int N         = 16,
    parameter int SIZE      = 4,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_stage,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_re,
    input  logic [DATA_W-1:0] din_im,
    output logic              en_wr,
    output logic [SIZE-1:0]   wr_ptr,
    output logic [DATA_W-1:0] wr_re,
    output logic [DATA_W-1:0] wr_im,
    output logic              stage_done,
    output logic              busy,
    output logic              err_unexp
);

    localparam int              C_PW     = SIZE - 1;
    localparam logic [SIZE-1:0] C_HALF   = SIZE'(1) << (stage_FFT - 1);
    localparam logic [C_PW-1:0] C_P_LAST = C_PW'(N / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_A = 2'd1,
        ST_WR_B = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [C_PW-1:0]   p_q, p_d;
    logic              en_wr_q, en_wr_d;
    logic [SIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] wr_re_q, wr_re_d;
    logic [DATA_W-1:0] wr_im_q, wr_im_d;
    logic              stage_done_q, stage_done_d;
    logic              err_unexp_q, err_unexp_d;

    logic [SIZE-1:0]   w_p_ext;
    logic [SIZE-1:0]   w_k;
    logic [SIZE-1:0]   w_addr_a;
    logic [SIZE-1:0]   w_addr_b;

    // Pair p lives in group g = p >> log2(H) at offset k = p & (H-1);
    // the group base is g * 2H, i.e. g shifted left by stage_FFT.
    always_comb begin
        w_p_ext  = {1'b0, p_q};
        w_k      = w_p_ext & (C_HALF - SIZE'(1));
        w_addr_a = ((w_p_ext >> (stage_FFT - 1)) << stage_FFT) + w_k;
        w_addr_b = w_addr_a + C_HALF;
    end

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        en_wr_d      = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        wr_re_d      = wr_re_q;
        wr_im_d      = wr_im_q;
        stage_done_d = 1'b0;
        err_unexp_d  = err_unexp_q;

        case (state_q)
            ST_IDLE: begin
                p_d = '0;
                if (din_valid) begin
                    err_unexp_d = 1'b1;
                end
                if (start_stage) begin
                    state_d = ST_WR_A;
                end
            end
            ST_WR_A: begin
                if (din_valid) begin
                    en_wr_d  = 1'b1;
                    wr_ptr_d = w_addr_a;
                    wr_re_d  = din_re;
                    wr_im_d  = din_im;
                    state_d  = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (din_valid) begin
                    en_wr_d  = 1'b1;
                    wr_ptr_d = w_addr_b;
                    wr_re_d  = din_re;
                    wr_im_d  = din_im;
                    p_d      = p_q + C_PW'(1);
                    state_d  = (p_q == C_P_LAST) ? ST_DONE : ST_WR_A;
                end
            end
            ST_DONE: begin
                if (din_valid) begin
                    err_unexp_d = 1'b1;
                end
                stage_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            en_wr_q      <= 1'b0;
            wr_ptr_q     <= '0;
            wr_re_q      <= '0;
            wr_im_q      <= '0;
            stage_done_q <= 1'b0;
            err_unexp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            en_wr_q      <= en_wr_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_re_q      <= wr_re_d;
            wr_im_q      <= wr_im_d;
            stage_done_q <= stage_done_d;
            err_unexp_q  <= err_unexp_d;
        end
    end

    // stage_done is raised as the FSM re-enters IDLE, so busy falls with it.
    assign busy       = (state_q != ST_IDLE);
    assign en_wr      = en_wr_q;
    assign wr_ptr     = wr_ptr_q;
    assign wr_re      = wr_re_q;
    assign wr_im      = wr_im_q;
    assign stage_done = stage_done_q;
    assign err_unexp  = err_unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_final_write_address_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_final_write_address_generator
// Description : Directed bench; three instances (stage 2, 3, 4) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_final_write_address_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stage = 1'b0;
    logic        din_valid = 1'b0;
    logic [15:0] din_re = '0;
    logic [15:0] din_im = '0;

    logic        en_wr      [3];
    logic [3:0]  wr_ptr     [3];
    logic [15:0] wr_re      [3];
    logic [15:0] wr_im      [3];
    logic        stage_done [3];
    logic        busy       [3];
    logic        err_unexp  [3];

    int n_vec = 0;
    int n_err = 0;

    int exp_addr [3][16] = '{
        '{0, 2, 1, 3, 4, 6, 5, 7, 8, 10, 9, 11, 12, 14, 13, 15},
        '{0, 4, 1, 5, 2, 6, 3, 7, 8, 12, 9, 13, 10, 14, 11, 15},
        '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15}
    };

    always #5 clk = ~clk;

    final_write_address_generator #(.stage_FFT(2), .N(16), .SIZE(4), .DATA_W(16)) u_dut_s2 (
        .clk(clk), .rst(rst), .start_stage(start_stage), .din_valid(din_valid),
        .din_re(din_re), .din_im(din_im), .en_wr(en_wr[0]), .wr_ptr(wr_ptr[0]),
        .wr_re(wr_re[0]), .wr_im(wr_im[0]), .stage_done(stage_done[0]),
        .busy(busy[0]), .err_unexp(err_unexp[0])
    );

    final_write_address_generator #(.stage_FFT(3), .N(16), .SIZE(4), .DATA_W(16)) u_dut_s3 (
        .clk(clk), .rst(rst), .start_stage(start_stage), .din_valid(din_valid),
        .din_re(din_re), .din_im(din_im), .en_wr(en_wr[1]), .wr_ptr(wr_ptr[1]),
        .wr_re(wr_re[1]), .wr_im(wr_im[1]), .stage_done(stage_done[1]),
        .busy(busy[1]), .err_unexp(err_unexp[1])
    );

    final_write_address_generator #(.stage_FFT(4), .N(16), .SIZE(4), .DATA_W(16)) u_dut_s4 (
        .clk(clk), .rst(rst), .start_stage(start_stage), .din_valid(din_valid),
        .din_re(din_re), .din_im(din_im), .en_wr(en_wr[2]), .wr_ptr(wr_ptr[2]),
        .wr_re(wr_re[2]), .wr_im(wr_im[2]), .stage_done(stage_done[2]),
        .busy(busy[2]), .err_unexp(err_unexp[2])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full stage of 16 samples; din_re carries the sample index.
    task automatic run_stage(input bit gaps, input bit mid_start);
        start_stage = 1'b1;
        tick();
        start_stage = 1'b0;
        chk("arm_busy", int'(busy[0]), 1);
        chk("arm_no_wr", int'(en_wr[0]), 0);
        for (int i = 0; i < 16; i++) begin
            din_valid   = 1'b1;
            din_re      = 16'(i);
            din_im      = 16'(16'hF000 + i);
            start_stage = mid_start && (i == 4);
            tick();
            start_stage = 1'b0;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("en_wr_s%0d_%0d", d + 2, i), int'(en_wr[d]), 1);
                chk($sformatf("wr_ptr_s%0d_%0d", d + 2, i), int'(wr_ptr[d]), exp_addr[d][i]);
            end
            chk($sformatf("wr_re_%0d", i), int'(wr_re[0]), i);
            chk($sformatf("wr_im_%0d", i), int'(wr_im[0]), 16'hF000 + i);
            if (gaps && i < 15) begin
                din_valid = 1'b0;
                tick();
                chk($sformatf("gap_en_%0d", i), int'(en_wr[0]), 0);
                chk($sformatf("gap_ptr_%0d", i), int'(wr_ptr[0]), exp_addr[0][i]);
                chk($sformatf("gap_re_%0d", i), int'(wr_re[0]), i);
            end
        end
        din_valid = 1'b0;
        chk("last_busy", int'(busy[0]), 1);
        chk("last_no_done", int'(stage_done[0]), 0);
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("done_s%0d", d + 2), int'(stage_done[d]), 1);
            chk($sformatf("done_busy_s%0d", d + 2), int'(busy[d]), 0);
        end
        chk("done_no_wr", int'(en_wr[0]), 0);
        chk("done_hold_ptr", int'(wr_ptr[0]), 15);
        tick();
        chk("done_pulse_end", int'(stage_done[0]), 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_en_wr", int'(en_wr[0]), 0);
        chk("rst_wr_ptr", int'(wr_ptr[0]), 0);
        chk("rst_wr_re", int'(wr_re[0]), 0);
        chk("rst_wr_im", int'(wr_im[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(stage_done[0]), 0);
        chk("rst_err", int'(err_unexp[0]), 0);
        rst = 1'b0;
        tick();

        // Consecutive samples, all three stage settings
        run_stage(1'b0, 1'b0);
        chk("err_clean", int'(err_unexp[0]), 0);

        // Back-to-back stage, start one cycle after stage_done
        run_stage(1'b0, 1'b0);

        // Alternating din_valid gaps
        run_stage(1'b1, 1'b0);

        // din_valid while idle: no write, sticky error
        din_valid = 1'b1;
        din_re    = 16'hABCD;
        tick();
        din_valid = 1'b0;
        chk("idle_din_no_wr", int'(en_wr[0]), 0);
        chk("idle_din_err", int'(err_unexp[0]), 1);
        chk("idle_din_hold_re", int'(wr_re[0]), 15);
        repeat (3) tick();
        chk("err_sticky", int'(err_unexp[0]), 1);

        // start_stage mid-stage ignored
        run_stage(1'b0, 1'b1);
        chk("err_sticky_after", int'(err_unexp[0]), 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", int'(err_unexp[0]), 0);

        // start_stage and din_valid together in IDLE
        start_stage = 1'b1;
        din_valid   = 1'b1;
        din_re      = 16'h1234;
        tick();
        start_stage = 1'b0;
        din_valid   = 1'b0;
        chk("both_no_wr", int'(en_wr[0]), 0);
        chk("both_busy", int'(busy[0]), 1);
        chk("both_err", int'(err_unexp[0]), 1);
        din_valid = 1'b1;
        din_re    = 16'd77;
        tick();
        din_valid = 1'b0;
        chk("both_first_ptr", int'(wr_ptr[0]), 0);
        chk("both_first_re", int'(wr_re[0]), 77);

        // Abort after 7 writes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_stage = 1'b1;
        tick();
        start_stage = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din_valid = 1'b1;
            din_re    = 16'(i);
            tick();
            chk($sformatf("pre_abort_ptr_%0d", i), int'(wr_ptr[0]), exp_addr[0][i]);
        end
        din_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_en_wr", int'(en_wr[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_ptr", int'(wr_ptr[0]), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort_no_done_%0d", i), int'(stage_done[0]), 0);
            chk($sformatf("abort_no_wr_%0d", i), int'(en_wr[0]), 0);
        end
        run_stage(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
